// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl
//   Drives the select (a) and enable (en) inputs of a downstream 4x16 decoder.
//   On start it scans the lines first..last, wrapping from 15 to 0. Each line
//   gets BLANK_CYCLES cycles with en=0 and then max(dwell,1) cycles with en=1,
//   so the decoder select only changes while the decoder is disabled. It runs
//   one frame, or repeats frames until stop when continuous=1.
//
//   Optional feature: define DECODER_SCAN_PAUSE_EN to add a 'pause' input.
//   While pause=1 the blank and dwell counters freeze during BLANK and DRIVE,
//   and a, en and the pulse outputs stay quiet.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   pause         (optional) freezes the scan in progress
//   start         begin a frame (ignored while busy)
//   stop          end the scan after the current line (ignored while idle)
//   continuous    repeat frames; sampled at start
//   dwell         drive cycles per line (0 acts as 1); sampled at start
//   first, last   line window; sampled at start
//   a, en         decoder select / enable (registered)
//   busy          scan in progress
//   line_done     pulse after each line finishes driving
//   frame_done    pulse after line 'last' finishes driving
module decoder_scan_ctrl #(
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
`ifdef DECODER_SCAN_PAUSE_EN
    input  logic               pause,
`endif
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [3:0]         first,
    input  logic [3:0]         last,
    output logic [3:0]         a,
    output logic               en,
    output logic               busy,
    output logic               line_done,
    output logic               frame_done
);

    localparam logic [3:0] BLANK_LAST = 4'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t             state;
    logic [3:0]         blank_cnt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_last;   // D-1, with dwell=0 folded onto D=1
    logic [3:0]         first_q;
    logic [3:0]         last_q;
    logic               cont_q;
    logic               stop_req;
    logic               stop_pending;
    logic               hold;

`ifdef DECODER_SCAN_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // A stop arriving in the very last drive cycle of a line still counts,
    // so the live input is merged with the sticky request.
    assign stop_pending = stop_req | stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            blank_cnt  <= '0;
            dwell_cnt  <= '0;
            dwell_last <= '0;
            first_q    <= '0;
            last_q     <= '0;
            cont_q     <= 1'b0;
            stop_req   <= 1'b0;
            a          <= '0;
            en         <= 1'b0;
            busy       <= 1'b0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    en   <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        dwell_last <= (dwell == '0) ? '0 : dwell - 1'b1;
                        first_q    <= first;
                        last_q     <= last;
                        cont_q     <= continuous;
                        stop_req   <= 1'b0;
                        a          <= first;
                        blank_cnt  <= '0;
                        busy       <= 1'b1;
                        state      <= BLANK;
                    end
                end

                BLANK: begin
                    if (stop) stop_req <= 1'b1;
                    if (!hold) begin
                        if (blank_cnt == BLANK_LAST) begin
                            blank_cnt <= '0;
                            dwell_cnt <= '0;
                            en        <= 1'b1;
                            state     <= DRIVE;
                        end else begin
                            blank_cnt <= blank_cnt + 1'b1;
                        end
                    end
                end

                DRIVE: begin
                    if (stop) stop_req <= 1'b1;
                    if (!hold) begin
                        if (dwell_cnt == dwell_last) begin
                            en        <= 1'b0;
                            dwell_cnt <= '0;
                            line_done <= 1'b1;
                            if (a == last_q) begin
                                frame_done <= 1'b1;
                                if (cont_q && !stop_pending) begin
                                    a     <= first_q;
                                    state <= BLANK;
                                end else begin
                                    busy  <= 1'b0;
                                    state <= IDLE;
                                end
                            end else if (stop_pending) begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                a     <= a + 1'b1;   // wraps 15 -> 0
                                state <= BLANK;
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt + 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl (BLANK_CYCLES=1, DWELL_W=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_decoder_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, continuous;
    logic [7:0] dwell;
    logic [3:0] first, last;
    logic [3:0] a;
    logic       en, busy, line_done, frame_done;
`ifdef DECODER_SCAN_PAUSE_EN
    logic       pause = 1'b0;
`endif

    int cmps = 0;
    int errs = 0;

    always #5 clk = ~clk;

    decoder_scan_ctrl #(.DWELL_W(8), .BLANK_CYCLES(1)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef DECODER_SCAN_PAUSE_EN
        .pause      (pause),
`endif
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .dwell      (dwell),
        .first      (first),
        .last       (last),
        .a          (a),
        .en         (en),
        .busy       (busy),
        .line_done  (line_done),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ea, input int een,
                           input int eb, input int eld, input int efd);
        chk({tag, ".a"}, int'(a), ea);
        chk({tag, ".en"}, int'(en), een);
        chk({tag, ".busy"}, int'(busy), eb);
        chk({tag, ".line_done"}, int'(line_done), eld);
        chk({tag, ".frame_done"}, int'(frame_done), efd);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; afterwards we sit in cycle N+1.
    task automatic do_start(input int f, input int l, input int d, input bit c);
        first = 4'(f); last = 4'(l); dwell = 8'(d); continuous = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Single-frame scan, B=1: line L occupies cycles 1+L*(1+D) .. (L+1)*(1+D).
    task automatic check_frame(input string tag, input int f, input int nl, input int d);
        int dd, per, ln, ph, c;
        dd  = (d == 0) ? 1 : d;
        per = 1 + dd;
        for (c = 1; c <= nl * per; c++) begin
            ln = (c - 1) / per;
            ph = (c - 1) % per;
            chk_all(tag, (f + ln) % 16, (ph != 0) ? 1 : 0, 1,
                    (ph == 0 && ln > 0) ? 1 : 0, 0);
            tick();
        end
        chk_all({tag, ".end"}, (f + nl - 1) % 16, 0, 0, 1, 1);
        tick();
        chk_all({tag, ".idle"}, (f + nl - 1) % 16, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        dwell = 8'd0; first = 4'd0; last = 4'd0;
        tick(); tick();
        chk_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Idle 20 cycles with start low
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_all("idle", 0, 0, 0, 0, 0);
        end

        // Full 0..15 frame, dwell 3: frame_done / busy low at cycle 65
        do_start(0, 15, 3, 1'b0);
        check_frame("full", 0, 16, 3);

        // Wrap 14,15,0,1 with dwell 0 treated as 1
        do_start(14, 1, 0, 1'b0);
        check_frame("wrap", 14, 4, 0);

        // start and stop together while idle: stop ignored, full 2-line frame
        stop = 1'b1;
        do_start(2, 3, 1, 1'b0);
        stop = 1'b0;
        check_frame("startstop", 2, 2, 1);

        // Continuous, first=last=5, dwell 2; stop in 2nd drive cycle of frame 3
        do_start(5, 5, 2, 1'b1);
        for (int c = 1; c <= 9; c++) begin
            chk_all("cont", 5, (c % 3 != 1) ? 1 : 0, 1,
                    (c == 4 || c == 7) ? 1 : 0, (c == 4 || c == 7) ? 1 : 0);
            if (c == 9) stop = 1'b1;
            tick();
            stop = 1'b0;
        end
        chk_all("cont.end", 5, 0, 0, 1, 1);
        tick();
        chk_all("cont.idle", 5, 0, 0, 0, 0);
        tick(); tick();
        chk_all("cont.hold", 5, 0, 0, 0, 0);

        // Stop on a non-last line: ends after that line, no frame_done
        do_start(8, 12, 1, 1'b0);
        stop = 1'b1;               // sampled in the first blank cycle of line 8
        tick();
        stop = 1'b0;
        chk_all("stopmid.drv", 8, 1, 1, 0, 0);
        tick();
        chk_all("stopmid.end", 8, 0, 0, 1, 0);

        // start while busy ignored, then reset mid-DRIVE
        do_start(3, 6, 4, 1'b0);
        chk_all("rb.c1", 3, 0, 1, 0, 0);
        tick();
        first = 4'd9; last = 4'd9; dwell = 8'd1;
        start = 1'b1;              // cycle 2: busy, must be ignored
        tick();
        start = 1'b0;
        chk_all("rb.c3", 3, 1, 1, 0, 0);
        tick(); tick(); tick();
        chk_all("rb.c6", 4, 0, 1, 1, 0);
        tick();
        chk_all("rb.c7", 4, 1, 1, 0, 0);
        rst = 1'b1;
        tick();
        chk_all("rb.rst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick(); tick();
        chk_all("rb.after", 0, 0, 0, 0, 0);

`ifdef DECODER_SCAN_PAUSE_EN
        // Pause 4 cycles mid-DRIVE, dwell 3: en high 7 cycles, line_done at 9
        do_start(7, 7, 3, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            chk_all("pause", 7, (c >= 2 && c <= 8) ? 1 : 0, (c <= 8) ? 1 : 0,
                    (c == 9) ? 1 : 0, (c == 9) ? 1 : 0);
            if (c == 3) pause = 1'b1;
            if (c == 7) pause = 1'b0;
            tick();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
